ascii_result_encoder: RTL

//  Converts one calculator result into an ASCII byte stream for the UART transmitter.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/ascii_result_encoder_if.sv | 24 ++
 rtl/bin_to_bcd_seq.sv | 47 ++++
 rtl/ascii_result_encoder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared kind codes, ASCII byte constants and FSM states for the result encoder.
package calc_pkg;

   typedef enum logic [1:0] {
      KIND_NUM  = 2'd0,
      KIND_BOOL = 2'd1,
      KIND_ERR  = 2'd2,
      KIND_RSVD = 2'd3
   } kind_e;

   localparam logic [7:0] ASC_0     = 8'h30;
   localparam logic [7:0] ASC_MINUS = 8'h2D;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;
   localparam logic [7:0] ASC_Y     = 8'h59;
   localparam logic [7:0] ASC_N     = 8'h4E;
   localparam logic [7:0] ASC_E     = 8'h45;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_SKIP,
      S_EMIT,
      S_CR,
      S_LF
   } state_e;

   // Decimal digits needed for the largest w-bit unsigned value.
   function automatic int dec_digits(input int w);
      longint unsigned v;
      int n;
      v = (64'd1 << w) - 64'd1;
      n = 0;
      do begin
         v = v / 64'd10;
         n++;
      end while (v != 64'd0);
      return n;
   endfunction

endpackage

// File: rtl/ascii_result_encoder_if.sv
// Result handshake and UART TX byte handshake between core, encoder and UART.
interface ascii_result_encoder_if #(
   parameter int RES_W = 16
);

   logic             res_valid;
   logic             res_ready;
   logic [RES_W-1:0] res_data;
   logic [1:0]       res_kind;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;

   modport master (
      output res_valid, res_data, res_kind, tx_ready,
      input  res_ready, tx_data, tx_valid
   );

   modport slave (
      input  res_valid, res_data, res_kind, tx_ready,
      output res_ready, tx_data, tx_valid
   );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: one input bit per cycle, RES_W cycles after start.
module bin_to_bcd_seq #(
   parameter int RES_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [RES_W-1:0]    bin,
   output logic                done,
   output logic [DIGITS*4-1:0] bcd
);

   localparam int CW = $clog2(RES_W + 1);

   logic [RES_W-1:0]    sh_q;
   logic [CW-1:0]       cnt_q;
   logic [DIGITS*4-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] > 4'd4)
            adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   // High during the final shift; bcd holds the result from the next cycle on.
   assign done = (cnt_q == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= '0;
         bcd   <= '0;
      end else if (start) begin
         sh_q  <= bin;
         cnt_q <= CW'(RES_W);
         bcd   <= '0;
      end else if (cnt_q != '0) begin
         bcd   <= {adj[DIGITS*4-2:0], sh_q[RES_W-1]};
         sh_q  <= {sh_q[RES_W-2:0], 1'b0};
         cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/ascii_result_encoder.sv
// Result -> ASCII line encoder (digits / Y / N / E, then CR LF).
// Define ASCII_ENC_SIGNED_EN to treat NUM results as two's complement.
module ascii_result_encoder
   import calc_pkg::*;
#(
   parameter int RES_W  = 16,
   parameter int DIGITS = 5,
   parameter bit CRLF   = 1'b1
) (
   input logic                   clk,
   input logic                   rst,
   ascii_result_encoder_if.slave bus
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (RES_W < 2 || RES_W > 32) begin : g_resw_chk
      $error("RES_W must be within 2..32");
   end
   if (DIGITS != dec_digits(RES_W)) begin : g_digits_chk
      $error("DIGITS does not match RES_W");
   end

   state_e              state_q;
   state_e              state_d;
   kind_e               kind_in;
   kind_e               kind_q;
   logic                bool_q;
   logic                neg_q;
   logic                neg_in;
   logic [IW-1:0]       dig_idx_q;
   logic [IW-1:0]       lead;
   logic [RES_W-1:0]    mag;
   logic [DIGITS*4-1:0] bcd;
   logic [3:0]          digit;
   logic                bcd_done;
   logic                accept;
   logic                xfer;
   logic                emit;
   logic                last_sym;

   assign kind_in = (bus.res_kind == KIND_RSVD) ? KIND_ERR
                                                 : kind_e'(bus.res_kind);

`ifdef ASCII_ENC_SIGNED_EN
   // Negating the most negative value yields 2^(RES_W-1) as unsigned.
   assign neg_in = bus.res_data[RES_W-1] & (kind_in == KIND_NUM);
   assign mag    = bus.res_data[RES_W-1] ? ('0 - bus.res_data)
                                         : bus.res_data;
`else
   assign neg_in = 1'b0;
   assign mag    = bus.res_data;
`endif

   assign bus.res_ready = (state_q == S_IDLE) & ~rst;
   assign bus.tx_valid  = (state_q == S_EMIT) |
                          (state_q == S_CR)   |
                          (state_q == S_LF);

   assign accept = bus.res_valid & bus.res_ready;
   assign xfer   = bus.tx_valid & bus.tx_ready;
   assign emit   = (state_q == S_EMIT);
   assign digit  = bcd[dig_idx_q*4 +: 4];

   assign last_sym = ~neg_q &
                     ((kind_q != KIND_NUM) | (dig_idx_q == '0));

   bin_to_bcd_seq #(
      .RES_W (RES_W),
      .DIGITS(DIGITS)
   ) u_bcd (
      .clk  (clk),
      .rst  (rst),
      .start(accept & (kind_in == KIND_NUM)),
      .bin  (mag),
      .done (bcd_done),
      .bcd  (bcd)
   );

   // Highest non-zero digit; all-zero leaves index 0 so a lone '0' is sent.
   always_comb begin
      lead = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] != 4'd0)
            lead = IW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (accept)
               state_d = (kind_in == KIND_NUM) ? S_CONV : S_EMIT;
         S_CONV:
            if (bcd_done)
               state_d = S_SKIP;
         S_SKIP:
            state_d = S_EMIT;
         S_EMIT:
            if (xfer && last_sym)
               state_d = CRLF ? S_CR : S_LF;
         S_CR:
            if (xfer)
               state_d = S_LF;
         S_LF:
            if (xfer)
               state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kind_q    <= KIND_ERR;
         bool_q    <= 1'b0;
         neg_q     <= 1'b0;
         dig_idx_q <= '0;
      end else begin
         if (accept) begin
            kind_q    <= kind_in;
            bool_q    <= bus.res_data[0];
            neg_q     <= neg_in;
            dig_idx_q <= '0;
         end
         if (state_q == S_SKIP)
            dig_idx_q <= lead;
         if (emit && xfer) begin
            if (neg_q)
               neg_q <= 1'b0;
            else if (dig_idx_q != '0)
               dig_idx_q <= dig_idx_q - IW'(1);
         end
      end
   end

   always_comb begin
      bus.tx_data = 8'h00;
      unique case (1'b1)
         emit & neg_q:
            bus.tx_data = ASC_MINUS;
         emit & ~neg_q & (kind_q == KIND_NUM):
            bus.tx_data = ASC_0 + {4'h0, digit};
         emit & (kind_q == KIND_BOOL):
            bus.tx_data = bool_q ? ASC_Y : ASC_N;
         emit & (kind_q == KIND_ERR):
            bus.tx_data = ASC_E;
         state_q == S_CR:
            bus.tx_data = ASC_CR;
         state_q == S_LF:
            bus.tx_data = ASC_LF;
         default:
            bus.tx_data = 8'h00;
      endcase
   end

endmodule
